// File: rtl/tri_bus_arbiter.sv
// rtl/tri_bus_arbiter.sv - round-robin arbiter for a 4-requester shared tri-state bus
module tri_bus_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic [3:0] bus_en,
    output logic [1:0] owner,
    output logic       busy
);

    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        TURN
    } state_t;

    state_t        state;
    logic [HW-1:0] hold_cnt;
    logic [1:0]    last_owner;
    logic [1:0]    winner;
    logic [1:0]    idx;
    logic          found;
    logic          release_bus;

    // Search begins just past the previous owner, so the last holder ranks lowest.
    always_comb begin
        winner = '0;
        idx    = '0;
        found  = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            idx = last_owner + 2'(i);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    assign release_bus = !req[owner] || (hold_cnt == HOLD_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= '0;
            bus_en     <= '0;
            owner      <= '0;
            busy       <= 1'b0;
            hold_cnt   <= '0;
            last_owner <= 2'd3;
        end else begin
            case (state)
                IDLE, TURN: begin
                    if (|req) begin
                        state      <= GRANT;
                        grant      <= 4'b0001 << winner;
                        bus_en     <= 4'b0001 << winner;
                        owner      <= winner;
                        busy       <= 1'b1;
                        last_owner <= winner;
                        hold_cnt   <= HW'(1);
                    end else begin
                        state  <= IDLE;
                        grant  <= '0;
                        bus_en <= '0;
                        owner  <= '0;
                        busy   <= 1'b0;
                    end
                end
                GRANT: begin
                    // Every release passes through TURN so enables never touch in adjacent cycles.
                    if (release_bus) begin
                        state    <= TURN;
                        grant    <= '0;
                        bus_en   <= '0;
                        owner    <= '0;
                        busy     <= 1'b0;
                        hold_cnt <= '0;
                    end else if (hold_cnt != HOLD_MAX) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    grant  <= '0;
                    bus_en <= '0;
                    owner  <= '0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tri_bus_arbiter.sv
// tb/tb_tri_bus_arbiter.sv - directed vector bench for tri_bus_arbiter
module tb_tri_bus_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] grant;
    logic [3:0] bus_en;
    logic [1:0] owner;
    logic       busy;

    int total = 0;
    int bad   = 0;
    logic [3:0] prev_grant = 4'b0000;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] exp_grant;
        string      tag;
    } vec_t;

    vec_t vecs[$];

    tri_bus_arbiter #(.MAX_HOLD(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .grant  (grant),
        .bus_en (bus_en),
        .owner  (owner),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1:0] owner_of(input logic [3:0] g);
        case (g)
            4'b0010: return 2'd1;
            4'b0100: return 2'd2;
            4'b1000: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    task automatic add(input logic r, input logic [3:0] rq, input logic [3:0] g, input int n, input string tag);
        vec_t v;
        for (int k = 0; k < n; k++) begin
            v.rst       = r;
            v.req       = rq;
            v.exp_grant = g;
            v.tag       = tag;
            vecs.push_back(v);
        end
    endtask

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Applies one cycle of inputs, then samples 1 ns after the edge.
    task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] g, input string name);
        rst = r;
        req = rq;
        @(posedge clk);
        #1;
        check({name, " grant"}, grant, g);
        check({name, " owner"}, {2'b00, owner}, {2'b00, owner_of(g)});
        check({name, " busy"}, {3'b000, busy}, {3'b000, (g != 4'b0000)});
        check({name, " bus_en==grant"}, bus_en, grant);
        check({name, " onehot0"}, {3'b000, $onehot0(grant)}, 4'b0001);
        check({name, " no direct handover"},
              {3'b000, (prev_grant != 4'b0000 && grant != 4'b0000 && prev_grant != grant)}, 4'b0000);
        prev_grant = grant;
    endtask

    initial begin
        rst = 1'b1;
        req = 4'b0000;

        add(1'b1, 4'b0101, 4'b0000, 2, "reset");
        // lowest-index first after reset, MAX_HOLD forced release, then index 2
        add(1'b0, 4'b0101, 4'b0001, 8, "r025_g0");
        add(1'b0, 4'b0101, 4'b0000, 1, "r025_turn");
        add(1'b0, 4'b0101, 4'b0100, 1, "r025_g2");
        add(1'b0, 4'b0000, 4'b0000, 3, "r025_idle");
        // all four requesting: full rotation with one turnaround between owners
        add(1'b1, 4'b1111, 4'b0000, 1, "r026_rst");
        add(1'b0, 4'b1111, 4'b0001, 8, "r026_g0");
        add(1'b0, 4'b1111, 4'b0000, 1, "r026_t0");
        add(1'b0, 4'b1111, 4'b0010, 8, "r026_g1");
        add(1'b0, 4'b1111, 4'b0000, 1, "r026_t1");
        add(1'b0, 4'b1111, 4'b0100, 8, "r026_g2");
        add(1'b0, 4'b1111, 4'b0000, 1, "r026_t2");
        add(1'b0, 4'b1111, 4'b1000, 8, "r026_g3");
        add(1'b0, 4'b1111, 4'b0000, 1, "r026_t3");
        add(1'b0, 4'b1111, 4'b0001, 8, "r026_g0b");
        add(1'b0, 4'b0000, 4'b0000, 2, "r026_end");
        // single requester dropping early
        add(1'b0, 4'b0010, 4'b0010, 3, "r027_g1");
        add(1'b0, 4'b0000, 4'b0000, 3, "r027_turn_idle");
        // non-owner pulse must not preempt nor be remembered
        add(1'b0, 4'b0100, 4'b0100, 2, "r028_g2");
        add(1'b0, 4'b1100, 4'b0100, 2, "r028_pulse");
        add(1'b0, 4'b0100, 4'b0100, 1, "r028_g2b");
        add(1'b0, 4'b0000, 4'b0000, 3, "r028_turn_idle");
        // sole requester forced out by MAX_HOLD is regranted after one TURN
        add(1'b0, 4'b0001, 4'b0001, 8, "r020_g0");
        add(1'b0, 4'b0001, 4'b0000, 1, "r020_turn");
        add(1'b0, 4'b0001, 4'b0001, 1, "r020_regrant");
        add(1'b0, 4'b0000, 4'b0000, 2, "r020_end");

        for (int i = 0; i < vecs.size(); i++)
            step(vecs[i].rst, vecs[i].req, vecs[i].exp_grant, $sformatf("%s[%0d]", vecs[i].tag, i));

        // reset in the middle of a grant to requester 3: enables drop at once, no TURN
        step(1'b0, 4'b1000, 4'b1000, "r029_g3_a");
        step(1'b0, 4'b1000, 4'b1000, "r029_g3_b");
        step(1'b0, 4'b1000, 4'b1000, "r029_g3_c");
        step(1'b1, 4'b1000, 4'b0000, "r029_rst");
        step(1'b0, 4'b1000, 4'b1000, "r029_regrant");
        step(1'b0, 4'b1000, 4'b1000, "r029_hold");
        step(1'b0, 4'b0000, 4'b0000, "r029_turn");
        step(1'b0, 4'b0000, 4'b0000, "r029_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
